// File: rtl/traffic_light_fsm.sv
// Traffic-light sequencer: steps main/side/walk lamps and hands each state's interval to the countdown timer.
// Build option: define FLASH_MODE_EN to add the night_mode input and the flashing-yellow FLASH state.
module traffic_light_fsm #(
  parameter logic [4:0] T_BASE = 5'd6,
  parameter logic [4:0] T_EXT  = 5'd3,
  parameter logic [4:0] T_YEL  = 5'd2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sensor,
  input  logic       walk_button,
  input  logic       expired,
  input  logic       one_hz_enable,
`ifdef FLASH_MODE_EN
  input  logic       night_mode,
`endif
  output logic       start_timer,
  output logic [4:0] value,
  output logic       main_red,
  output logic       main_yel,
  output logic       main_grn,
  output logic       side_red,
  output logic       side_yel,
  output logic       side_grn,
  output logic       walk
);

  typedef enum logic [2:0] {
    S_MG1  = 3'd0,
    S_MG2  = 3'd1,
    S_MY   = 3'd2,
    S_WALK = 3'd3,
    S_SG1  = 3'd4,
    S_SG2  = 3'd5,
    S_SY   = 3'd6
`ifdef FLASH_MODE_EN
    , S_FLASH = 3'd7
`endif
  } state_t;

  state_t state_p0;
  state_t state_nxt;
  logic   rst_p0;
  logic   entry_p0;
  logic   armed_p0;
  logic   walk_pend_p0;
  logic   advance;
  logic   entry_nxt;
  logic   armed_nxt;
  logic   walk_clr;

  function automatic logic [4:0] interval_of(input state_t s);
    case (s)
      S_MG1, S_MG2, S_SG1: interval_of = T_BASE;
      S_MY, S_SY:          interval_of = T_YEL;
      S_WALK, S_SG2:       interval_of = T_EXT;
      default:             interval_of = T_BASE;
    endcase
  endfunction

`ifdef FLASH_MODE_EN
  logic flash_yel_p0;
`else
  logic unused_tick;
  assign unused_tick = one_hz_enable;
`endif

  // Next state: a timed state only advances once armed, so an expired left
  // high from the previous interval cannot skip the freshly entered state.
  always_comb begin
    state_nxt = state_p0;
    advance   = 1'b0;
    if (armed_p0 && expired) begin
      advance = 1'b1;
      case (state_p0)
        S_MG1:  state_nxt = S_MG2;
        S_MG2:  state_nxt = S_MY;
        S_MY:   state_nxt = walk_pend_p0 ? S_WALK : S_SG1;
        S_WALK: state_nxt = S_SG1;
        S_SG1:  state_nxt = sensor ? S_SG2 : S_SY;
        S_SG2:  state_nxt = S_SY;
        S_SY: begin
`ifdef FLASH_MODE_EN
          state_nxt = night_mode ? S_FLASH : S_MG1;
`else
          state_nxt = S_MG1;
`endif
        end
        default: state_nxt = S_MG1;
      endcase
    end
`ifdef FLASH_MODE_EN
    if (state_p0 == S_FLASH) begin
      advance   = !night_mode;
      state_nxt = night_mode ? S_FLASH : S_MG1;
    end
`endif
  end

  always_comb begin
    entry_nxt = advance;
`ifdef FLASH_MODE_EN
    if (state_nxt == S_FLASH) entry_nxt = 1'b0;
`endif
    walk_clr  = advance && (state_nxt == S_WALK);
    armed_nxt = armed_p0;
    if (advance)       armed_nxt = 1'b0;
    else if (entry_p0) armed_nxt = 1'b1;
  end

  // State register: leaving reset counts as an entry into MG1 so the timer is loaded.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_p0     <= S_MG1;
      rst_p0       <= 1'b1;
      entry_p0     <= 1'b0;
      armed_p0     <= 1'b0;
      walk_pend_p0 <= 1'b0;
    end else begin
      state_p0     <= state_nxt;
      rst_p0       <= 1'b0;
      entry_p0     <= rst_p0 | entry_nxt;
      armed_p0     <= armed_nxt;
      walk_pend_p0 <= walk_button | (walk_pend_p0 & ~walk_clr);
    end
  end

`ifdef FLASH_MODE_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      flash_yel_p0 <= 1'b0;
    end else if (advance && (state_nxt == S_FLASH)) begin
      flash_yel_p0 <= 1'b1;
    end else if ((state_p0 == S_FLASH) && one_hz_enable) begin
      flash_yel_p0 <= ~flash_yel_p0;
    end
  end
`endif

  assign start_timer = entry_p0;
  assign value       = interval_of(state_p0);

  // Lamp decode: purely from registered state, both reds while held in reset.
  always_comb begin
    main_red = 1'b0;
    main_yel = 1'b0;
    main_grn = 1'b0;
    side_red = 1'b0;
    side_yel = 1'b0;
    side_grn = 1'b0;
    walk     = 1'b0;
    if (rst_p0) begin
      main_red = 1'b1;
      side_red = 1'b1;
    end else begin
      case (state_p0)
        S_MG1, S_MG2: begin
          main_grn = 1'b1;
          side_red = 1'b1;
        end
        S_MY: begin
          main_yel = 1'b1;
          side_red = 1'b1;
        end
        S_WALK: begin
          main_red = 1'b1;
          side_red = 1'b1;
          walk     = 1'b1;
        end
        S_SG1, S_SG2: begin
          main_red = 1'b1;
          side_grn = 1'b1;
        end
        S_SY: begin
          main_red = 1'b1;
          side_yel = 1'b1;
        end
`ifdef FLASH_MODE_EN
        S_FLASH: begin
          side_red = 1'b1;
          main_yel = flash_yel_p0;
        end
`endif
        default: begin
          main_red = 1'b1;
          side_red = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Randomized bench for traffic_light_fsm: a bench timer drives expired, a cycle-level reference model
// predicts every state entry into a scoreboard, and a monitor checks start pulses and lamps each cycle.
module tb_traffic_light_fsm;
  localparam int TB = 6;
  localparam int TE = 3;
  localparam int TY = 2;
  localparam int MG1 = 0, MG2 = 1, MY = 2, WLK = 3, SG1 = 4, SG2 = 5, SY = 6, FLS = 7;
  localparam logic [6:0] RST_LAMPS = 7'b1001000;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic sensor = 1'b0;
  logic walk_button = 1'b0;
  logic expired = 1'b0;
  logic one_hz_enable = 1'b0;
`ifdef FLASH_MODE_EN
  logic night_mode = 1'b0;
`endif
  logic       start_timer;
  logic [4:0] value;
  logic       main_red, main_yel, main_grn, side_red, side_yel, side_grn, walk;

  traffic_light_fsm dut (
    .clock(clock),
    .reset(reset),
    .sensor(sensor),
    .walk_button(walk_button),
    .expired(expired),
    .one_hz_enable(one_hz_enable),
`ifdef FLASH_MODE_EN
    .night_mode(night_mode),
`endif
    .start_timer(start_timer),
    .value(value),
    .main_red(main_red),
    .main_yel(main_yel),
    .main_grn(main_grn),
    .side_red(side_red),
    .side_yel(side_yel),
    .side_grn(side_grn),
    .walk(walk)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    int         val;
    logic [6:0] lamps;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // lamp vector order: main r/y/g, side r/y/g, walk
  int         interval_tab[8] = '{TB, TB, TY, TE, TB, TE, TY, TB};
  logic [6:0] lamp_tab[8]     = '{7'b0011000, 7'b0011000, 7'b0101000, 7'b1001001,
                                  7'b1000010, 7'b1000010, 7'b1000100, 7'b1001000};

  int m_st    = MG1;
  int m_dwell = 0;
  bit m_pend  = 1'b0;
  bit m_rst   = 1'b1;
  bit m_fy    = 1'b0;

  int tcnt    = 0;
  bit tmr_exp = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int next_of(input int s, input bit pend, input bit sens, input bit night);
    case (s)
      MG1:     return MG2;
      MG2:     return MY;
      MY:      return pend ? WLK : SG1;
      WLK:     return SG1;
      SG1:     return sens ? SG2 : SY;
      SG2:     return SY;
      SY:      return night ? FLS : MG1;
      default: return MG1;
    endcase
  endfunction

  // Reference model: every timed state is held at least two cycles, then
  // advances on the first cycle expired is seen.
  always @(posedge clock) begin
    bit   night;
    bit   adv;
    int   nxt;
    exp_t e;
    night = 1'b0;
`ifdef FLASH_MODE_EN
    night = night_mode;
`endif
    cyc++;
    if (!reset) begin
      m_rst   = 1'b1;
      m_st    = MG1;
      m_dwell = 0;
      m_pend  = 1'b0;
      m_fy    = 1'b0;
    end else begin
      adv = 1'b0;
      nxt = m_st;
      if (m_rst) begin
        m_rst = 1'b0;
        adv   = 1'b1;
        nxt   = MG1;
      end else if (m_st == FLS) begin
        if (!night) begin
          adv = 1'b1;
          nxt = MG1;
        end else if (one_hz_enable) begin
          m_fy = ~m_fy;
        end
      end else if (m_dwell >= 1 && expired) begin
        adv = 1'b1;
        nxt = next_of(m_st, m_pend, sensor, night);
      end
      if (adv && nxt == WLK) m_pend = 1'b0;
      if (walk_button) m_pend = 1'b1;
      if (adv) begin
        m_st    = nxt;
        m_dwell = 0;
        if (nxt == FLS) begin
          m_fy = 1'b1;
        end else begin
          e.cyc   = cyc;
          e.val   = interval_tab[nxt];
          e.lamps = lamp_tab[nxt];
          sb_q.push_back(e);
        end
      end else begin
        m_dwell++;
      end
    end
  end

  // Monitor: lamps/value every cycle, start pulses against the scoreboard.
  always @(negedge clock) begin
    logic [6:0] lamps_dut;
    logic [6:0] lamps_exp;
    exp_t       e;
    lamps_dut = {main_red, main_yel, main_grn, side_red, side_yel, side_grn, walk};
    if (m_rst)            lamps_exp = RST_LAMPS;
    else if (m_st == FLS) lamps_exp = {1'b0, m_fy, 1'b0, 1'b1, 3'b000};
    else                  lamps_exp = lamp_tab[m_st];
    check(m_rst ? "reset_lamps" : "lamps", int'(lamps_dut), int'(lamps_exp));
    if (m_rst) begin
      check("reset_value", int'(value), TB);
      check("reset_start", int'(start_timer), 0);
    end else if (m_st != FLS) begin
      check("value_hold", int'(value), interval_tab[m_st]);
    end
    if (start_timer) begin
      if (sb_q.size() == 0) begin
        check("unexpected_start", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("start_cycle", cyc, e.cyc);
        check("start_value", int'(value), e.val);
        check("start_lamps", int'(lamps_dut), int'(e.lamps));
      end
    end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      check("missing_start", 0, 1);
    end
  end

  // mode 0: bench timer, mode 1: expired held high, mode 2: random expired
  task automatic drive_cycle(input int mode, input int p_sensor, input int p_walk, input int p_tick);
    @(negedge clock);
    one_hz_enable = ($urandom_range(99) < p_tick);
    if (start_timer) begin
      tcnt    = int'(value);
      tmr_exp = 1'b0;
    end else if (one_hz_enable && tcnt > 0) begin
      tcnt--;
      if (tcnt == 0) tmr_exp = 1'b1;
    end
    case (mode)
      0:       expired = tmr_exp;
      1:       expired = 1'b1;
      default: expired = ($urandom_range(2) == 0);
    endcase
    sensor      = ($urandom_range(99) < p_sensor);
    walk_button = ($urandom_range(99) < p_walk);
  endtask

  initial begin
    int mode;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;

    repeat (70) drive_cycle(0, 0, 0, 100);

    for (int i = 0; i < 100 && m_st != MG1; i++) drive_cycle(0, 0, 0, 100);
    drive_cycle(0, 0, 100, 100);
    repeat (90) drive_cycle(0, 100, 0, 100);

    repeat (150) drive_cycle(1, 50, 20, 100);

    for (int i = 0; i < 100 && m_st != SG2; i++) drive_cycle(1, 100, 100, 100);
    reset = 1'b0;
    drive_cycle(1, 100, 0, 100);
    reset = 1'b1;
    repeat (40) drive_cycle(1, 0, 0, 100);

    for (int k = 0; k < 30; k++) begin
      mode = $urandom_range(2);
      repeat (100) begin
        reset = ($urandom_range(299) != 0);
`ifdef FLASH_MODE_EN
        if ($urandom_range(39) == 0) night_mode = ~night_mode;
`endif
        drive_cycle(mode, 50, 5, 50);
      end
    end

    reset = 1'b1;
`ifdef FLASH_MODE_EN
    night_mode = 1'b0;
`endif
    repeat (40) drive_cycle(1, 0, 0, 100);
    @(negedge clock);
    #1;
    check("sb_drain", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
